if_fetch: RTL and testbench

Instruction-fetch stage directly upstream of the decode stage.
- Holds the PC and fetches each 32-bit instruction as four little-endian bytes over a byte-wide memory-controller handshake.
- Presents {pc_o, inst_o} under a valid/stall handshake, then advances PC by 4.
- Accepts redirects (jump/branch targets) from EX, discarding in-flight work.

---
 rtl/if_fetch_pkg.sv | 16 +
 rtl/if_byte_asm.sv | 37 +++
 rtl/if_fetch.sv | 127 ++++++++++++
 tb/tb_if_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, constants and IF state encodings.
// IF_MISALIGN_TRAP_EN adds the IF_FAULT state.
package if_fetch_pkg;
    localparam int INST_ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;
    localparam logic RST_ENABLE = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IF_IDLE, IF_FETCH, IF_HOLD, IF_FAULT} if_state_e;
`else
    typedef enum logic [1:0] {IF_IDLE, IF_FETCH, IF_HOLD} if_state_e;
`endif
    function automatic logic [INST_ADDR_W-1:0] align_word(input logic [INST_ADDR_W-1:0] a);
        return a & ~(INST_ADDR_W'(3));
    endfunction
endpackage

// File: rtl/if_byte_asm.sv
// if_byte_asm: gathers four little-endian bytes into one instruction word.
module if_byte_asm
    import if_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [7:0]        byte_i,
    output logic              done_o,
    output logic [INST_W-1:0] word_o
);
    logic [1:0]      cnt_q;
    logic [3:0][7:0] bytes_q;
    logic [3:0][7:0] merged;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            cnt_q   <= 2'd0;
            bytes_q <= '0;
        end else if (clr_i) begin
            cnt_q <= 2'd0;
        end else if (load_i) begin
            cnt_q          <= cnt_q + 2'd1;
            bytes_q[cnt_q] <= byte_i;
        end
    end

    // The final byte is merged combinationally so the word is ready on the done edge.
    always_comb begin
        merged = bytes_q;
        if (load_i) merged[cnt_q] = byte_i;
    end

    assign done_o = load_i && cnt_q == 2'd3;
    assign word_o = merged;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC, byte-wide instruction fetch, valid/stall handoff to decode and EX redirects.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirect targets trap into FAULT instead of being aligned.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   jump_i,
    input  logic [INST_ADDR_W-1:0] jump_addr_i,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [7:0]             mem_rdata_i,
    output logic                   inst_valid_o,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic                   misalign_o
`endif
);
    if_state_e              state_q;
    logic [INST_ADDR_W-1:0] pc_q, tgt_q, tgt, redir_tgt;
    logic                   pend_q, fetch_ack, discard, load, done;
    logic [INST_W-1:0]      asm_word;

`ifdef IF_MISALIGN_TRAP_EN
    logic misalign_q, tgt_ok, redir_ok;
    assign tgt        = jump_addr_i;
    assign tgt_ok     = tgt[1:0] == 2'b00;
    assign redir_ok   = redir_tgt[1:0] == 2'b00;
    assign misalign_o = misalign_q;
`else
    assign tgt = align_word(jump_addr_i);
`endif
    assign redir_tgt = jump_i ? tgt : tgt_q;
    assign fetch_ack = state_q == IF_FETCH && mem_ack_i;
    assign discard   = fetch_ack && (jump_i || pend_q);
    assign load      = fetch_ack && !discard;

    if_byte_asm u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (discard),
        .load_i (load),
        .byte_i (mem_rdata_i),
        .done_o (done),
        .word_o (asm_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q      <= IF_IDLE;
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            pend_q       <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            inst_valid_o <= 1'b0;
            pc_o         <= '0;
            inst_o       <= ZERO_WORD;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else if (state_q != IF_FETCH && jump_i) begin
            pc_q         <= tgt;
            mem_addr_o   <= tgt;
            inst_valid_o <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q   <= !tgt_ok;
            mem_req_o    <= tgt_ok;
            state_q      <= tgt_ok ? IF_FETCH : IF_FAULT;
            if (!tgt_ok) pc_o <= tgt;
`else
            mem_req_o    <= 1'b1;
            state_q      <= IF_FETCH;
`endif
        end else begin
            case (state_q)
                IF_IDLE: begin
                    state_q    <= IF_FETCH;
                    mem_req_o  <= 1'b1;
                    mem_addr_o <= pc_q;
                end
                IF_HOLD: if (!stall_i) begin
                    inst_valid_o <= 1'b0;
                    pc_q         <= pc_q + 32'd4;
                    mem_req_o    <= 1'b1;
                    mem_addr_o   <= pc_q + 32'd4;
                    state_q      <= IF_FETCH;
                end
                IF_FETCH: begin
                    // An acked request cannot be reused after a redirect: drop req one cycle, restart via IDLE.
                    if (discard) begin
                        pend_q    <= 1'b0;
                        pc_q      <= redir_tgt;
                        mem_req_o <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
                        misalign_q <= !redir_ok;
                        state_q    <= redir_ok ? IF_IDLE : IF_FAULT;
                        if (!redir_ok) pc_o <= redir_tgt;
`else
                        state_q   <= IF_IDLE;
`endif
                    end else if (load) begin
                        if (done) begin
                            mem_req_o    <= 1'b0;
                            inst_valid_o <= 1'b1;
                            pc_o         <= pc_q;
                            inst_o       <= asm_word;
                            state_q      <= IF_HOLD;
                        end else begin
                            mem_addr_o <= mem_addr_o + 32'd1;
                        end
                    end else if (jump_i) begin
                        pend_q <= 1'b1;
                        tgt_q  <= tgt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: vector table, multi-cycle corner sequences and a randomized run against a PC-level model.
module tb_if_fetch;
    logic        clk = 1'b0, rst = 1'b0, stall_i = 1'b0, jump_i = 1'b0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic [7:0]  mem_rdata_i = '0;
    logic        mem_req_o, inst_valid_o;
    logic [31:0] mem_addr_o, pc_o, inst_o;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif
    int n_cmp = 0, n_err = 0;
    int ack_delay = 0, wc = 0;
    bit rand_ack = 1'b0;

    typedef struct {
        logic        stall;
        logic        jump;
        logic [31:0] jaddr;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;
    vec_t tbl[20];

    if_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    // Memory image: a NOP-like 0x13 at address 0, hashed bytes elsewhere.
    function automatic logic [7:0] mem_f(input logic [31:0] a);
        if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
        return 8'(a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return {mem_f(a + 32'd3), mem_f(a + 32'd2), mem_f(a + 32'd1), mem_f(a)};
    endfunction

    function automatic vec_t mk(input logic st, input logic jp, input logic [31:0] ja, input logic rq,
                                input logic [31:0] ad, input logic vl, input logic [31:0] p, input logic [31:0] i);
        vec_t v;
        v.stall = st; v.jump = jp; v.jaddr = ja; v.req = rq;
        v.addr = ad; v.valid = vl; v.pc = p; v.inst = i;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; stall_i = 1'b0; jump_i = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    // Byte-wide memory controller: fixed ack delay or random acks, garbage data when not acking.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!mem_req_o) begin
                mem_ack_i = 1'b0; wc = 0; mem_rdata_i = 8'($urandom);
            end else if (rand_ack ? ($urandom_range(0, 2) != 0) : (wc >= ack_delay)) begin
                mem_ack_i = 1'b1; mem_rdata_i = mem_f(mem_addr_o); wc = 0;
            end else begin
                mem_ack_i = 1'b0; wc++; mem_rdata_i = 8'($urandom);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc, p_addr;
        logic        p_req, p_ack, bad8;
        int          c0, cv, st, n_acc;
        bit          found;

        for (int i = 0; i < 4; i++) tbl[i] = mk(0, 0, 0, 1, 32'(i), 0, 0, 0);
        for (int i = 4; i < 10; i++) tbl[i] = mk(1, 0, 0, 0, 0, 1, 32'h0, 32'h0000_0013);
        tbl[10] = mk(0, 0, 0, 1, 32'h4, 0, 0, 0);
        for (int i = 11; i < 14; i++) tbl[i] = mk(0, 0, 0, 1, 32'(i - 6), 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 32'h4, word(32'h4));
        tbl[15] = mk(0, 1, 32'h43, 1, 32'h40, 0, 0, 0);
        for (int i = 16; i < 19; i++) tbl[i] = mk(0, 0, 0, 1, 32'h40 + 32'(i - 15), 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 1, 32'h40, word(32'h40));

        repeat (2) @(posedge clk);
        #2;
        chk("rst_req", mem_req_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_inst", inst_o, 0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            stall_i = tbl[i].stall; jump_i = tbl[i].jump; jump_addr_i = tbl[i].jaddr;
            @(posedge clk); #2;
            chk($sformatf("vec%0d_req", i), mem_req_o, tbl[i].req);
            if (tbl[i].req) chk($sformatf("vec%0d_addr", i), mem_addr_o, tbl[i].addr);
            chk($sformatf("vec%0d_valid", i), inst_valid_o, tbl[i].valid);
            if (tbl[i].valid) begin
                chk($sformatf("vec%0d_pc", i), pc_o, tbl[i].pc);
                chk($sformatf("vec%0d_inst", i), inst_o, tbl[i].inst);
            end
        end
        jump_i = 1'b0;

        // Slow memory: three idle cycles before every ack.
        ack_delay = 3;
        do_reset();
        c0 = -1; cv = -1; p_req = 0; p_ack = 0; p_addr = 0;
        for (int c = 0; c < 40 && cv < 0; c++) begin
            @(posedge clk); #2;
            if (p_req && !p_ack) chk("slow_addr_hold", mem_addr_o, p_addr);
            if (mem_req_o && c0 < 0) c0 = c;
            if (inst_valid_o) cv = c;
            p_req = mem_req_o; p_ack = mem_ack_i; p_addr = mem_addr_o;
        end
        chk("slow_latency", 32'(cv - c0), 32'd16);
        chk("slow_inst", inst_o, 32'h0000_0013);

        // Redirect while byte 1 of pc=0x8 is outstanding.
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #2;
            found = mem_req_o && mem_addr_o == 32'h9;
        end
        chk("jmp_reach_9", 32'(found), 1);
        jump_i = 1'b1; jump_addr_i = 32'h100;
        @(posedge clk); #2;
        jump_i = 1'b0;
        st = 0; bad8 = 0; found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (inst_valid_o && pc_o == 32'h8) bad8 = 1;
            if (inst_valid_o) begin
                found = 1;
                chk("jmp_pc", pc_o, 32'h100);
                chk("jmp_inst", inst_o, word(32'h100));
            end else if (st == 0 && !mem_req_o) begin
                st = 1;
            end else if (st == 1 && mem_req_o) begin
                chk("jmp_next_addr", mem_addr_o, 32'h100);
                st = 2;
            end
            if (!found) begin
                @(posedge clk); #2;
            end
        end
        chk("jmp_valid_seen", 32'(found), 1);
        chk("jmp_req_dropped", 32'(st), 2);
        chk("jmp_no_pc8", 32'(bad8), 0);

        // Asynchronous reset while byte 2 is being fetched, then while an instruction is held.
        ack_delay = 0; found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(posedge clk); #2;
            found = mem_req_o && mem_addr_o[1:0] == 2'd2;
        end
        chk("arst_reach_b2", 32'(found), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", mem_req_o, 0);
        chk("arst_valid", inst_valid_o, 0);
        chk("arst_addr", mem_addr_o, 0);
        #1 rst = 1'b1;
        @(posedge clk); #2;
        chk("arst_refetch_req", mem_req_o, 1);
        chk("arst_refetch_addr", mem_addr_o, 32'h0);
        stall_i = 1'b1; found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #2;
            found = inst_valid_o;
        end
        chk("arst_hold_seen", 32'(found), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_hold_valid", inst_valid_o, 0);
        chk("arst_hold_pc", pc_o, 0);
        chk("arst_hold_inst", inst_o, 0);
        #1 rst = 1'b1;

        // Random acks, stalls and redirects against a model that only tracks the next PC to present.
        rand_ack = 1'b1;
        do_reset();
        exp_pc = 32'h0; n_acc = 0; p_req = 0; p_ack = 0; p_addr = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #2;
            if (p_req && !p_ack) begin
                chk("rnd_req_hold", mem_req_o, 1);
                chk("rnd_addr_hold", mem_addr_o, p_addr);
            end
            if (inst_valid_o) begin
                chk("rnd_pc", pc_o, exp_pc);
                chk("rnd_inst", inst_o, word(exp_pc));
            end
            p_req = mem_req_o; p_ack = mem_ack_i; p_addr = mem_addr_o;
            stall_i = $urandom_range(0, 3) == 0;
            jump_i = $urandom_range(0, 24) == 0;
            jump_addr_i = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : 32'($urandom_range(0, 1023));
            if (jump_i) exp_pc = jump_addr_i & ~32'd3;
            else if (inst_valid_o && !stall_i) begin
                exp_pc = exp_pc + 32'd4;
                n_acc++;
            end
        end
        chk("rnd_progress", 32'(n_acc >= 50), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
